// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the run-time even clock divider.
// Imported by the controller and its phase generator.
package clk_div_ctrl_pkg;

    localparam int HW_DFLT           = 8;
    localparam int DEFAULT_HALF_DFLT = 2;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_phase.sv
// Half-period counter and divided clock generator.
// Restarts high on start, toggles at every phase end while running.
module clk_div_phase
    import clk_div_ctrl_pkg::*;
#(
    parameter int HW = HW_DFLT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [HW-1:0] half_act,
    input  logic          active,
    input  logic          run,
    output logic          phase_end,
    output logic          low_end,
    output logic          clk_div,
    output logic          rise
);

    localparam logic [HW-1:0] ONE = {{(HW-1){1'b0}}, 1'b1};

    logic [HW-1:0] cnt;
    logic [HW-1:0] last;

    assign last      = half_act - ONE;
    assign phase_end = active & (cnt == last);
    assign low_end   = phase_end & ~clk_div;

    // run low means the next cycle is OFF; active low means a fresh start
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt     <= '0;
            clk_div <= 1'b0;
            rise    <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            clk_div <= 1'b0;
            rise    <= 1'b0;
        end else if (!active) begin
            cnt     <= '0;
            clk_div <= 1'b1;
            rise    <= 1'b1;
        end else if (phase_end) begin
            cnt     <= '0;
            clk_div <= ~clk_div;
            rise    <= ~clk_div;
        end else begin
            cnt     <= cnt + ONE;
            rise    <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for an even clock divider.
// Ratio and start/stop changes land only on period boundaries.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int HW           = HW_DFLT,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DFLT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_cfg_valid,
    input  logic [HW-1:0] i_cfg_half,
    output logic          o_cfg_ready,
    output logic          o_cfg_err,
    output logic          o_clk_div,
    output logic          o_edge,
    output logic          o_running
);

    localparam logic [HW-1:0] HALF_RST = HW'(DEFAULT_HALF);

    state_e        state;
    state_e        state_n;
    logic [HW-1:0] half_act;
    logic [HW-1:0] half_pend;
    logic          pending;
    logic          err;

    logic          active;
    logic          run;
    logic          phase_end;
    logic          low_end;
    logic          clk_div;
    logic          rise;

    logic          xfer;
    logic          xfer_ok;
    logic          bypass;
    logic          apply;

    assign active  = (state != OFF);
    assign xfer    = i_cfg_valid & ~pending;
    assign xfer_ok = xfer & (|i_cfg_half);
    // config arriving with enable in OFF starts straight at the new ratio
    assign bypass  = (state == OFF) & i_en & xfer_ok;
    assign apply   = pending & ((state == OFF) | low_end);

    always_comb begin
        state_n = state;
        unique case (1'b1)
            (state == OFF):  if (i_en) state_n = RUN;
            (state == RUN):  if (!i_en) state_n = STOP;
            (state == STOP): begin
                if (i_en)
                    state_n = RUN;
                else if (low_end)
                    state_n = OFF;
            end
            default: state_n = OFF;
        endcase
    end

    assign run = (state_n != OFF);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= OFF;
            half_act  <= HALF_RST;
            half_pend <= HALF_RST;
            pending   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            err   <= xfer & ~(|i_cfg_half);
            if (bypass)
                half_act <= i_cfg_half;
            else if (apply)
                half_act <= half_pend;
            if (apply)
                pending <= 1'b0;
            else if (xfer_ok & ~bypass)
                pending <= 1'b1;
            if (xfer_ok & ~bypass)
                half_pend <= i_cfg_half;
        end
    end

    clk_div_phase #(
        .HW(HW)
    ) u_phase (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .half_act  (half_act),
        .active    (active),
        .run       (run),
        .phase_end (phase_end),
        .low_end   (low_end),
        .clk_div   (clk_div),
        .rise      (rise)
    );

    assign o_cfg_ready = ~pending;
    assign o_cfg_err   = err;
    assign o_clk_div   = clk_div;
    assign o_edge      = rise;
    assign o_running   = active;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with a period-position model.
// Every cycle is compared; literal patterns pin the key scenarios.
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] half = 8'd0;
    logic       rdy, err, cdiv, edg, running;

    int tests = 0;
    int fails = 0;

    clk_div_ctrl #(
        .HW(8),
        .DEFAULT_HALF(2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_cfg_valid (valid),
        .i_cfg_half  (half),
        .o_cfg_ready (rdy),
        .o_cfg_err   (err),
        .o_clk_div   (cdiv),
        .o_edge      (edg),
        .o_running   (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: position inside the whole period, 0..2h-1
    int m_h = 2;
    int m_pos = 0;
    int m_pend = 2;
    bit m_on = 0;
    bit m_pv = 0;
    bit m_err = 0;
    bit m_enp = 0;

    task automatic m_reset();
        m_h = 2; m_pos = 0; m_pend = 2;
        m_on = 0; m_pv = 0; m_err = 0; m_enp = 0;
    endtask

    task automatic m_step(input bit e, input bit v, input int h);
        bit xf, ok;
        xf = v && !m_pv;
        ok = xf && (h != 0);
        m_err = xf && (h == 0);
        if (!m_on) begin
            if (m_pv) begin
                m_h = m_pend;
                m_pv = 0;
            end
            if (e) begin
                if (ok) begin
                    m_h = h;
                    ok = 0;
                end
                m_on = 1;
                m_pos = 0;
                m_enp = 1;
            end
        end else begin
            if (m_pos == 2 * m_h - 1) begin
                if (m_pv) begin
                    m_h = m_pend;
                    m_pv = 0;
                end
                m_pos = 0;
                if (!m_enp && !e)
                    m_on = 0;
            end else begin
                m_pos++;
            end
            m_enp = e;
        end
        if (ok) begin
            m_pend = h;
            m_pv = 1;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst)
            m_reset();
        else
            m_step(en, valid, int'(half));
    end

    initial forever begin
        @(negedge clk);
        chk("m_clk_div", {31'd0, cdiv},
            {31'd0, m_on && (m_pos < m_h)});
        chk("m_edge", {31'd0, edg},
            {31'd0, m_on && (m_pos == 0)});
        chk("m_running", {31'd0, running}, {31'd0, m_on});
        chk("m_ready", {31'd0, rdy}, {31'd0, !m_pv});
        chk("m_err", {31'd0, err}, {31'd0, m_err});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [15:0] cap, cap2, cap3;

    initial begin
        tick();
        tick();
        chk("rst_clk", {31'd0, cdiv}, 32'd0);
        chk("rst_edge", {31'd0, edg}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_run", {31'd0, running}, 32'd0);
        chk("rst_rdy", {31'd0, rdy}, 32'd1);
        rst = 1'b0;
        tick();
        chk("idle_run", {31'd0, running}, 32'd0);

        // start at default half=2
        en = 1'b1;
        cap = '0; cap2 = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cap[i] = cdiv;
            cap2[i] = edg;
        end
        chk("a_clk", {24'd0, cap[7:0]}, 32'b00110011);
        chk("a_edge", {24'd0, cap2[7:0]}, 32'b00010001);
        chk("a_run", {31'd0, running}, 32'd1);

        // zero half rejected
        valid = 1'b1;
        half = 8'd0;
        cap = '0; cap2 = '0; cap3 = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            valid = 1'b0;
            cap[i] = cdiv;
            cap2[i] = err;
            cap3[i] = rdy;
        end
        chk("b_clk", {28'd0, cap[3:0]}, 32'b0011);
        chk("b_err", {28'd0, cap2[3:0]}, 32'b0001);
        chk("b_rdy", {28'd0, cap3[3:0]}, 32'b1111);

        // half=5 offered on second high cycle
        cap = '0; cap2 = '0; cap3 = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            valid = (i == 1);
            half = 8'd5;
            cap[i] = cdiv;
            cap2[i] = edg;
            cap3[i] = rdy;
        end
        chk("c_clk", {16'd0, cap}, 32'b1100000111110011);
        chk("c_edge", {16'd0, cap2}, 32'b0100000000010001);
        chk("c_rdy", {16'd0, cap3}, 32'b1111111111110011);

        // move to half=3, land on first high cycle
        valid = 1'b1;
        half = 8'd3;
        tick();
        valid = 1'b0;
        repeat (8) tick();
        chk("j_edge", {31'd0, edg}, 32'd1);
        chk("j_clk", {31'd0, cdiv}, 32'd1);

        // stop request on first high cycle
        en = 1'b0;
        cap = '0; cap2 = '0;
        for (int i = 0; i < 7; i++) begin
            tick();
            cap[i] = cdiv;
            cap2[i] = running;
        end
        chk("d_clk", {25'd0, cap[6:0]}, 32'b0000011);
        chk("d_run", {25'd0, cap2[6:0]}, 32'b0011111);

        // restart, stop, then re-enable in low phase
        en = 1'b1;
        cap = '0; cap2 = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) en = 1'b0;
            if (i == 3) en = 1'b1;
            cap[i] = cdiv;
            cap2[i] = running;
        end
        chk("l_clk", {20'd0, cap[11:0]}, 32'b000111000111);
        chk("l_run", {20'd0, cap2[11:0]}, 32'hfff);

        // go OFF, then enable and config together
        en = 1'b0;
        for (int i = 0; i < 40 && running; i++) tick();
        chk("e_off", {31'd0, running}, 32'd0);
        chk("e_off_clk", {31'd0, cdiv}, 32'd0);
        en = 1'b1;
        valid = 1'b1;
        half = 8'd4;
        cap = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            valid = 1'b0;
            cap[i] = cdiv;
        end
        chk("e_clk", {22'd0, cap[9:0]}, 32'b1100001111);

        // async reset mid high phase with a config pending
        valid = 1'b1;
        half = 8'd7;
        tick();
        valid = 1'b0;
        chk("f_pend", {31'd0, rdy}, 32'd0);
        chk("f_high", {31'd0, cdiv}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("f_clk", {31'd0, cdiv}, 32'd0);
        chk("f_run", {31'd0, running}, 32'd0);
        chk("f_rdy", {31'd0, rdy}, 32'd1);
        chk("f_edge", {31'd0, edg}, 32'd0);
        tick();
        rst = 1'b0;
        cap = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cap[i] = cdiv;
        end
        chk("f_restart", {26'd0, cap[5:0]}, 32'b110011);

        // half=1 gives divide-by-2
        valid = 1'b1;
        half = 8'd1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 20 && !edg; i++) tick();
        chk("g_edge", {31'd0, edg}, 32'd1);
        cap = '0; cap2 = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cap[i] = cdiv;
            cap2[i] = edg;
        end
        chk("g_clk", {26'd0, cap[5:0]}, 32'b101010);
        chk("g_edges", {26'd0, cap2[5:0]}, 32'b101010);

        // transfer coinciding with a low-phase end waits one period
        tick();
        valid = 1'b1;
        half = 8'd3;
        cap = '0; cap2 = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            valid = 1'b0;
            cap[i] = cdiv;
            cap2[i] = rdy;
        end
        chk("n_clk", {24'd0, cap[7:0]}, 32'b00011101);
        chk("n_rdy", {24'd0, cap2[7:0]}, 32'b11111100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
